pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 6, width of the multi-cycle length input and internal counter.
REQ-002 Parameter RST_PC, default 32'h00000000, value of new_pc while idle and after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stallreq_id  input  1  ID hazard request (load-use); level, honoured each cycle it is high.
REQ-006 ex_start  input  1  EX begins a multi-cycle op; one-cycle pulse.
REQ-007 ex_cycles  input  CNT_W  total stall length of that op, sampled with ex_start.
REQ-008 stallreq_mem  input  1  MEM not ready; level, held until data returns.
REQ-009 excp_req  input  1  exception request; requester holds it until flush is observed.
REQ-010 excp_vector  input  32  handler address, sampled with an accepted excp_req.
REQ-011 stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-012 flush  output  1  one-cycle pulse clearing all pipeline registers.
REQ-013 new_pc  output  32  redirect target, valid while flush is high.
REQ-014 busy  output  1  high in any state other than RUN.

Function
REQ-015 States SHALL be RUN, EX_WAIT, FLUSH, with a CNT_W-bit down-counter cnt.
REQ-016 stall SHALL be combinational from state and inputs; flush and new_pc SHALL be registered.
REQ-017 Priority per cycle: accepted exception > stallreq_mem > EX multi-cycle > stallreq_id > none.
REQ-018 stallreq_mem high -> stall = 6'b011111 in any state except FLUSH.
REQ-019 EX stall (ex_start in RUN, or state EX_WAIT) without mem stall -> stall = 6'b001111.
REQ-020 stallreq_id alone -> stall = 6'b000111; no stall source -> 6'b000000.
REQ-021 ex_start in RUN SHALL stall in that same cycle; ex_cycles of 0 or 1 SHALL stay in RUN (one stall cycle total).
REQ-022 ex_start in RUN with ex_cycles = N >= 2 SHALL go to EX_WAIT with cnt = N-1; total EX stall = exactly N cycles.
REQ-023 In EX_WAIT, each edge with stallreq_mem low decrements cnt; at the edge where cnt == 1 the state returns to RUN.
REQ-024 In EX_WAIT, stallreq_mem high SHALL freeze cnt (no decrement).
REQ-025 ex_start in EX_WAIT or FLUSH SHALL be ignored.
REQ-026 excp_req SHALL be accepted at an edge in RUN or EX_WAIT only when stallreq_mem is low; otherwise it stays pending.
REQ-027 Acceptance SHALL latch excp_vector into new_pc, set flush = 1, enter FLUSH, and clear cnt (aborting EX_WAIT).
REQ-028 FLUSH lasts exactly one cycle: stall = 6'b000000, flush = 1; next edge -> RUN, flush = 0.
REQ-029 excp_req still high in FLUSH SHALL be ignored; a new request is acceptable from the following RUN cycle.
REQ-030 new_pc SHALL hold its last value when flush is low.

Reset
REQ-031 rst low SHALL immediately force state RUN, cnt 0, flush 0, new_pc RST_PC, busy 0.
REQ-032 While rst is low, stall SHALL be 6'b000000 regardless of inputs.
REQ-033 Reset mid-EX_WAIT or mid-FLUSH SHALL abandon the operation; no stall or flush persists after release.
REQ-034 First edge after rst release behaves as RUN with all inputs honoured.

Verification
REQ-035 stallreq_id high 2 cycles -> stall 000111 for exactly those 2 cycles, busy 0.
REQ-036 ex_start with ex_cycles 5 -> stall 001111 for 5 consecutive cycles, busy high for cycles 2-5, then 000000.
REQ-037 ex_cycles 4 with stallreq_mem high 3 cycles mid-wait -> stall 011111 those 3 cycles, 001111 total still 4 cycles, 7-cycle window.
REQ-038 excp_req with vector 32'h00000020 during EX_WAIT -> next cycle flush 1, new_pc 32'h00000020, stall 000000; following cycle RUN, flush 0.
REQ-039 excp_req while stallreq_mem high -> no flush until mem stall drops; flush one edge later.
REQ-040 rst pulsed low in EX_WAIT (cnt 3) -> stall 000000 immediately; after release, no residual stall.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/stall requests from the pipeline stages and
// the stall/flush/redirect controls driven back by pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    // Handshake: stallreq_id and stallreq_mem are levels sampled every cycle;
    // ex_start is a one-cycle pulse qualifying ex_cycles; excp_req is held by the
    // requester (with excp_vector stable) until it observes flush high, and is
    // accepted only on an edge outside FLUSH while stallreq_mem is low.
    logic             stallreq_id;
    logic             ex_start;
    logic [CNT_W-1:0] ex_cycles;
    logic             stallreq_mem;
    logic             excp_req;
    logic [31:0]      excp_vector;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             busy;

    modport master (
        input  stallreq_id, ex_start, ex_cycles, stallreq_mem, excp_req, excp_vector,
        output stall, flush, new_pc, busy
    );

    modport slave (
        output stallreq_id, ex_start, ex_cycles, stallreq_mem, excp_req, excp_vector,
        input  stall, flush, new_pc, busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: arbitrates ID, EX multi-cycle and MEM stalls
// and turns an accepted exception into a one-cycle flush with a redirect PC.
module pipe_ctrl #(
    parameter int          CNT_W  = 6,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.master      bus,
    output logic [1:0]       dbg_state_o,
    output logic [CNT_W-1:0] dbg_cnt_o
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EX_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_q;
    logic [31:0]      new_pc_q;
    logic             excp_accept;
    logic [5:0]       stall_c;

    // Exceptions wait out a memory stall and are never taken during FLUSH itself.
    assign excp_accept = bus.excp_req && !bus.stallreq_mem && (state_q != ST_FLUSH);

    always_comb begin
        stall_c = 6'b000000;
        if (!rst || state_q == ST_FLUSH) begin
            stall_c = 6'b000000;
        end else if (bus.stallreq_mem) begin
            stall_c = 6'b011111;
        end else if (state_q == ST_EX_WAIT || (state_q == ST_RUN && bus.ex_start)) begin
            stall_c = 6'b001111;
        end else if (bus.stallreq_id) begin
            stall_c = 6'b000111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            new_pc_q <= RST_PC;
        end else if (excp_accept) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            flush_q  <= 1'b1;
            new_pc_q <= bus.excp_vector;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // The start cycle is itself the first stall cycle, so N cycles
                    // total leaves N-1 to count down in EX_WAIT.
                    if (bus.ex_start && bus.ex_cycles >= CNT_W'(2)) begin
                        state_q <= ST_EX_WAIT;
                        cnt_q   <= bus.ex_cycles - CNT_W'(1);
                    end
                end
                ST_EX_WAIT: begin
                    if (!bus.stallreq_mem) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.stall   = stall_c;
    assign bus.flush   = flush_q;
    assign bus.new_pc  = new_pc_q;
    assign bus.busy    = (state_q != ST_RUN);
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, checked
// per cycle against a cycle-count reference model through an expected queue.
module tb_pipe_ctrl;
    localparam int          CNT_W  = 6;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          W      = 40;

    logic             clk;
    logic             rst;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    pipe_ctrl_if #(.CNT_W(CNT_W)) intf ();

    pipe_ctrl #(.CNT_W(CNT_W), .RST_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (intf.master),
        .dbg_state_o (dbg_state),
        .dbg_cnt_o   (dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: remaining EX stall cycles owed, flush-cycle flag, outputs
    int          ex_owed;
    bit          in_flush;
    bit          m_flush;
    logic [31:0] m_pc;
    bit          obs_flush;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    task automatic drive(input bit r, input bit id, input bit es, input int n,
                         input bit mem, input bit ex, input logic [31:0] vec);
        logic [5:0] s;
        bit         busy;
        bit         accept;
        @(posedge clk);
        #1;
        rst                    = r;
        intf.stallreq_id  = id;
        intf.ex_start     = es;
        intf.ex_cycles    = CNT_W'(n);
        intf.stallreq_mem = mem;
        intf.excp_req     = ex;
        intf.excp_vector  = vec;
        if (!r) begin
            ex_owed  = 0;
            in_flush = 0;
            m_flush  = 0;
            m_pc     = RST_PC;
        end
        if (!r || in_flush)                  s = 6'b000000;
        else if (mem)                        s = 6'b011111;
        else if (ex_owed > 0 || es)          s = 6'b001111;
        else if (id)                         s = 6'b000111;
        else                                 s = 6'b000000;
        busy = in_flush || (ex_owed > 0);
        exp_q.push_back({busy, m_flush, m_pc, s});
        obs_flush = m_flush;
        if (r) begin
            accept = ex && !mem && !in_flush;
            if (accept) begin
                in_flush = 1;
                m_flush  = 1;
                m_pc     = vec;
                ex_owed  = 0;
            end else if (in_flush) begin
                in_flush = 0;
                m_flush  = 0;
            end else begin
                m_flush = 0;
                if (ex_owed > 0) begin
                    if (!mem) ex_owed = ex_owed - 1;
                end else if (es) begin
                    ex_owed = (n > 1) ? n - 1 : 0;
                end
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {intf.busy, intf.flush, intf.new_pc, intf.stall};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_out @%0t: got stall=%b flush=%b new_pc=%h busy=%b, expected stall=%b flush=%b new_pc=%h busy=%b",
                             $time, a[5:0], a[38], a[37:6], a[39], e[5:0], e[38], e[37:6], e[39]);
                end
            end
        end
    end

    initial begin
        bit          mem_on;
        bit          ex_hold;
        logic [31:0] ex_vec;
        bit          es;
        bit          id;
        bit          r;
        int          n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        intf.stallreq_id = 0; intf.ex_start = 0; intf.ex_cycles = '0;
        intf.stallreq_mem = 0; intf.excp_req = 0; intf.excp_vector = '0;
        ex_owed = 0; in_flush = 0; m_flush = 0; m_pc = RST_PC; obs_flush = 0;

        // reset, with noisy inputs that must not stall
        drive(0, 1, 1, 5, 1, 1, 32'hdead_beef);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        // ID stall for exactly two cycles
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        // EX of 5 cycles
        drive(1, 0, 1, 5, 0, 0, 32'h0);
        idle(6);
        // EX of 4 cycles with a 3-cycle MEM stall in the middle
        drive(1, 0, 1, 4, 0, 0, 32'h0);
        idle(1);
        repeat (3) drive(1, 0, 0, 0, 1, 0, 32'h0);
        idle(4);
        // EX lengths 0 and 1: one stall cycle each; ex_start in EX_WAIT ignored
        drive(1, 0, 1, 0, 0, 0, 32'h0);
        drive(1, 0, 1, 1, 0, 0, 32'h0);
        drive(1, 0, 1, 3, 0, 0, 32'h0);
        drive(1, 0, 1, 9, 0, 0, 32'h0);
        idle(3);
        // exception during EX_WAIT, held through the flush cycle
        drive(1, 0, 1, 5, 0, 0, 32'h0);
        idle(1);
        drive(1, 0, 0, 0, 0, 1, 32'h0000_0020);
        drive(1, 0, 1, 4, 0, 1, 32'h0000_0020);
        idle(3);
        // exception blocked by MEM stall until it drops
        repeat (3) drive(1, 0, 0, 0, 1, 1, 32'h0000_0040);
        drive(1, 0, 0, 0, 0, 1, 32'h0000_0040);
        drive(1, 0, 0, 0, 0, 1, 32'h0000_0040);
        idle(2);
        // back-to-back exceptions: second taken from the following RUN cycle
        drive(1, 0, 0, 0, 0, 1, 32'h0000_0080);
        drive(1, 0, 0, 0, 0, 1, 32'h0000_00c0);
        drive(1, 0, 0, 0, 0, 1, 32'h0000_00c0);
        idle(2);
        // reset in EX_WAIT with cnt 3
        drive(1, 0, 1, 6, 0, 0, 32'h0);
        idle(2);
        drive(0, 1, 0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        idle(3);
        // reset mid-FLUSH
        drive(1, 0, 0, 0, 0, 1, 32'h0000_1234);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // randomized traffic
        mem_on = 0; ex_hold = 0; ex_vec = '0;
        for (int i = 0; i < 3000; i++) begin
            if (ex_hold && obs_flush) ex_hold = 0;
            if (mem_on) mem_on = ($urandom_range(0, 9) < 7);
            else        mem_on = ($urandom_range(0, 9) < 1);
            if (!ex_hold && $urandom_range(0, 19) == 0) begin
                ex_hold = 1;
                ex_vec  = $urandom;
            end
            es = ($urandom_range(0, 7) == 0);
            if (es && mem_on && !in_flush && ex_owed == 0) es = 0;
            n  = $urandom_range(0, 9);
            id = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 199) != 0);
            if (!r) ex_hold = 0;
            drive(r, id, es, n, mem_on, ex_hold, ex_vec);
        end
        idle(2);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
